// File: rtl/dse3w_tx_if.sv
// Byte handshake between an upstream source and the DSE3W transmit encoder.
interface dse3w_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/dse3w_tx.sv
// DSE3W 3-wire data-strobe transmit encoder: LSB-first, one wire toggle per bit.
// Optional odd-parity 9th symbol when DSE3W_PARITY_EN is defined.
module dse3w_tx #(
  parameter int unsigned DIV = 4
) (
  input  logic           clk,
  input  logic           rst,
  dse3w_tx_if.slave      tx,
  output logic [2:0]     line,
  output logic           busy
);

`ifdef DSE3W_PARITY_EN
  localparam int unsigned N = 9;
`else
  localparam int unsigned N = 8;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

  state_t         state_r, state_n;
  logic [2:0]     line_r, line_n;
  logic [1:0]     l_r, l_n;
  logic [N-1:0]   sh_r, sh_n, frame_s;
  logic [7:0]     sym_r, sym_n;
  logic [3:0]     bit_r, bit_n;
  logic           tog_s, tog_bit_s;
  logic [1:0]     idx_s;

  // Wire toggled for a bit value given the last toggled wire: 0 -> L+1, 1 -> L+2 (mod 3).
  function automatic logic [1:0] next_wire(input logic [1:0] last, input logic bit_v);
    logic [1:0] r;
    case (last)
      2'd0:    r = bit_v ? 2'd2 : 2'd1;
      2'd1:    r = bit_v ? 2'd0 : 2'd2;
      default: r = bit_v ? 2'd1 : 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

`ifdef DSE3W_PARITY_EN
  assign frame_s = {odd_parity(tx.tx_data), tx.tx_data};
`else
  assign frame_s = tx.tx_data;
`endif

  // Next-state and datapath: GAP reuses the symbol counter for two DIV-long halves
  always_comb begin
    state_n   = state_r;
    sh_n      = sh_r;
    sym_n     = sym_r;
    bit_n     = bit_r;
    tog_s     = 1'b0;
    tog_bit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tx.tx_valid) begin
          tog_s     = 1'b1;
          tog_bit_s = tx.tx_data[0];
          sh_n      = frame_s >> 1'b1;
          sym_n     = 8'd0;
          bit_n     = 4'd0;
          state_n   = SHIFT;
        end else begin
          state_n   = IDLE;
        end
      end
      SHIFT: begin
        if (sym_r == 8'(DIV - 1)) begin
          sym_n = 8'd0;
          if (bit_r == 4'(N - 1)) begin
            bit_n   = 4'd0;
            state_n = GAP;
          end else begin
            bit_n     = bit_r + 4'd1;
            tog_s     = 1'b1;
            tog_bit_s = sh_r[0];
            sh_n      = sh_r >> 1'b1;
          end
        end else begin
          sym_n = sym_r + 8'd1;
        end
      end
      GAP: begin
        if (sym_r == 8'(DIV - 1)) begin
          sym_n = 8'd0;
          if (bit_r == 4'd1) begin
            bit_n   = 4'd0;
            state_n = IDLE;
          end else begin
            bit_n   = 4'd1;
          end
        end else begin
          sym_n = sym_r + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    idx_s = next_wire(l_r, tog_bit_s);
    if (tog_s) begin
      line_n = line_r ^ (3'b001 << idx_s);
      l_n    = idx_s;
    end else begin
      line_n = line_r;
      l_n    = l_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      line_r  <= 3'b000;
      l_r     <= 2'd2;
      sh_r    <= '0;
      sym_r   <= 8'd0;
      bit_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      line_r  <= line_n;
      l_r     <= l_n;
      sh_r    <= sh_n;
      sym_r   <= sym_n;
      bit_r   <= bit_n;
    end
  end

  assign tx.tx_ready = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign line        = line_r;

endmodule
